// File: rtl/mem_array_arbiter.sv
// Round-robin arbiter for the shared memory array bus: one-hot registered grants,
// bus-turnaround idle cycles between owners, and MAX_HOLD pre-emption.
module mem_array_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       resetH,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int TURN_W = $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } arbStateT;

    arbStateT             state, stateNext;
    logic [IDX_W-1:0]     rrPtr, rrPtrNext;
    logic [HOLD_W-1:0]    holdCnt, holdNext;
    logic [TURN_W-1:0]    turnCnt, turnNext;
    logic [NUM_REQ-1:0]   gntNext;
    logic [IDX_W-1:0]     ownerNext;
    logic                 timeoutNext;

    // Round-robin search: rotate req so rrPtr lands on bit 0, take the lowest set bit,
    // then map the offset back to an absolute index modulo NUM_REQ.
    logic [NUM_REQ-1:0]   reqRot;
    logic                 anyReq;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       winnerSum;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W:0]       ptrSum;
    logic [IDX_W-1:0]     winnerPlusOne;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        reqRot        = NUM_REQ'({req, req} >> rrPtr);
        anyReq        = 1'b0;
        offset        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!anyReq && reqRot[i]) begin
                anyReq = 1'b1;
                offset = IDX_W'(i);
            end
        end

        winnerSum = {1'b0, rrPtr} + {1'b0, offset};
        if (winnerSum >= (IDX_W + 1)'(NUM_REQ)) begin
            winnerSum = winnerSum - (IDX_W + 1)'(NUM_REQ);
        end
        winner = winnerSum[IDX_W-1:0];

        ptrSum = {1'b0, winner} + (IDX_W + 1)'(1);
        if (ptrSum == (IDX_W + 1)'(NUM_REQ)) begin
            ptrSum = '0;
        end
        winnerPlusOne = ptrSum[IDX_W-1:0];
    end

    logic doArb;

    always_comb begin
        stateNext   = state;
        gntNext     = gnt;
        ownerNext   = owner;
        rrPtrNext   = rrPtr;
        holdNext    = holdCnt;
        turnNext    = turnCnt;
        timeoutNext = 1'b0;
        doArb       = 1'b0;

        case (state)
            IDLE: begin
                doArb = 1'b1;
            end

            GRANT: begin
                // Release beats pre-emption, so done on the MAX_HOLD edge is a clean release.
                if (done[owner] || !req[owner]) begin
                    gntNext   = '0;
                    stateNext = TURN;
                    turnNext  = TURN_W'(1);
                end else if (holdCnt == HOLD_W'(MAX_HOLD)) begin
                    gntNext     = '0;
                    timeoutNext = 1'b1;
                    stateNext   = TURN;
                    turnNext    = TURN_W'(1);
                end else begin
                    holdNext = holdCnt + 1'b1;
                end
            end

            TURN: begin
                if (turnCnt == TURN_W'(TURN_CYCLES)) begin
                    doArb = 1'b1;
                    if (!anyReq) begin
                        stateNext = IDLE;
                        turnNext  = '0;
                    end
                end else begin
                    turnNext = turnCnt + 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
                gntNext   = '0;
            end
        endcase

        if (doArb && anyReq) begin
            gntNext   = NUM_REQ'(1) << winner;
            ownerNext = winner;
            rrPtrNext = winnerPlusOne;
            holdNext  = HOLD_W'(1);
            stateNext = GRANT;
        end
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state       <= IDLE;
            gnt         <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rrPtr       <= '0;
            holdCnt     <= '0;
            turnCnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= stateNext;
            gnt         <= gntNext;
            owner       <= ownerNext;
            busy        <= |gntNext;
            timeout_err <= timeoutNext;
            rrPtr       <= rrPtrNext;
            holdCnt     <= holdNext;
            turnCnt     <= turnNext;
        end
    end

endmodule

// File: tb/tb_mem_array_arbiter.sv
// Self-checking bench for mem_array_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-free behavioural model.
module tb_mem_array_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int MAX_HOLD    = 16;
    localparam int TURN_CYCLES = 1;

    logic               clk = 1'b0;
    logic               resetH;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] gnt;
    logic [1:0]         owner;
    logic               busy;
    logic               timeout_err;

    int checks   = 0;
    int failures = 0;

    mem_array_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MAX_HOLD   (MAX_HOLD),
        .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk        (clk),
        .resetH     (resetH),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .owner      (owner),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!resetH) begin
            checks++;
            assert ($onehot0(gnt)) else begin
                failures++;
                $display("FAIL gnt_onehot: got %b expected zero or one-hot", gnt);
            end
        end
    end

    // Behavioural model: owner index (-1 = none), cycles held, idle gap remaining.
    int mCur, mPtr, mHeld, mGap, mLast;
    bit mTerr;

    task automatic modelReset();
        mCur = -1; mPtr = 0; mHeld = 0; mGap = 0; mLast = 0; mTerr = 0;
    endtask

    task automatic modelArb(input logic [NUM_REQ-1:0] r);
        bit found = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int m = (mPtr + k) % NUM_REQ;
            if (!found && r[m]) begin
                found = 1; mCur = m; mLast = m; mPtr = (m + 1) % NUM_REQ; mHeld = 1;
            end
        end
    endtask

    task automatic modelStep(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] d);
        mTerr = 0;
        if (mCur >= 0) begin
            if (d[mCur] || !r[mCur]) begin
                mCur = -1; mGap = TURN_CYCLES;
            end else if (mHeld == MAX_HOLD) begin
                mCur = -1; mGap = TURN_CYCLES; mTerr = 1;
            end else begin
                mHeld++;
            end
        end else if (mGap > 0) begin
            mGap--;
            if (mGap == 0) modelArb(r);
        end else begin
            modelArb(r);
        end
    endtask

    task automatic doReset();
        resetH = 1'b1; req = '0; done = '0;
        repeat (2) @(negedge clk);
        resetH = 1'b0;
        modelReset();
    endtask

    function automatic int gntIndex(input logic [NUM_REQ-1:0] g);
        int idx = -1;
        for (int i = 0; i < NUM_REQ; i++) if (g[i]) idx = i;
        return idx;
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] expGnt;
        int         expOwner;
        logic       expBusy;
        logic       expTerr;
    } vecT;

    vecT vecs[13];

    initial begin
        int highCnt;
        bit terrSeen;
        int waited;
        int rate;

        vecs[0]  = '{4'b0100, 4'b0000, 4'b0100, 2, 1'b1, 1'b0};
        vecs[1]  = '{4'b0101, 4'b0100, 4'b0000, 2, 1'b0, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 2, 1'b0, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 2, 1'b0, 1'b0};
        vecs[4]  = '{4'b1001, 4'b0000, 4'b1000, 3, 1'b1, 1'b0};
        vecs[5]  = '{4'b1001, 4'b1000, 4'b0000, 3, 1'b0, 1'b0};
        vecs[6]  = '{4'b0001, 4'b0000, 4'b0001, 0, 1'b1, 1'b0};
        vecs[7]  = '{4'b0001, 4'b1000, 4'b0001, 0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0010, 4'b0000, 4'b0010, 1, 1'b1, 1'b0};
        vecs[10] = '{4'b0010, 4'b1000, 4'b0010, 1, 1'b1, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 1, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 1, 1'b0, 1'b0};

        resetH = 1'b1; req = '0; done = '0;
        #1;
        check("reset_gnt", int'(gnt), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_owner", int'(owner), 0);
        check("reset_terr", int'(timeout_err), 0);

        // Vector table: single request, wrap from rr_ptr=3, non-owner done ignored.
        doReset();
        for (int i = 0; i < 13; i++) begin
            req = vecs[i].req; done = vecs[i].done;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), int'(gnt), int'(vecs[i].expGnt));
            check($sformatf("vec%0d_owner", i), int'(owner), vecs[i].expOwner);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].expBusy));
            check($sformatf("vec%0d_terr", i), int'(timeout_err), int'(vecs[i].expTerr));
        end

        // Reset mid-grant: gnt must drop without waiting for a clock edge.
        doReset();
        req = 4'b0010;
        @(negedge clk);
        check("midreset_pre_gnt", int'(gnt), 2);
        #2 resetH = 1'b1;
        #1;
        check("midreset_gnt_async", int'(gnt), 0);
        check("midreset_busy_async", int'(busy), 0);
        @(negedge clk);
        resetH = 1'b0; req = '0;
        @(negedge clk);
        check("midreset_owner", int'(owner), 0);
        check("midreset_idle_gnt", int'(gnt), 0);

        // Round-robin fairness with all masters requesting.
        doReset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (gnt == '0 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            if (g > 0) check("rr_gap_cycles", waited, TURN_CYCLES);
            check("rr_order", gntIndex(gnt), g % NUM_REQ);
            repeat (2) @(negedge clk);
            done = gnt;
            @(negedge clk);
            done = '0;
            check("rr_release", int'(gnt), 0);
        end

        // Pre-emption after MAX_HOLD cycles, then regrant of the same master.
        doReset();
        req = 4'b0001;
        @(negedge clk);
        highCnt = 0; terrSeen = 0;
        for (int k = 0; k < 40 && gnt[0]; k++) begin
            highCnt++;
            if (timeout_err) terrSeen = 1;
            @(negedge clk);
        end
        check("timeout_hold_cycles", highCnt, MAX_HOLD);
        check("timeout_no_early_err", int'(terrSeen), 0);
        check("timeout_pulse", int'(timeout_err), 1);
        check("timeout_gap_gnt", int'(gnt), 0);
        @(negedge clk);
        check("timeout_regrant", int'(gnt), 1);
        check("timeout_pulse_end", int'(timeout_err), 0);

        // done on the MAX_HOLD edge is a normal release; non-owner done is ignored.
        doReset();
        req = 4'b0010;
        @(negedge clk);
        for (int k = 1; k < MAX_HOLD; k++) begin
            done = (k == 5) ? 4'b1000 : 4'b0000;
            @(negedge clk);
        end
        check("nonowner_done_ignored", int'(gnt), 2);
        done = 4'b0010;
        @(negedge clk);
        done = '0;
        check("simul_release_gnt", int'(gnt), 0);
        check("simul_release_terr", int'(timeout_err), 0);

        // Randomized traffic against the behavioural model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            rate = (c < 1500) ? 8 : 40;
            for (int b = 0; b < NUM_REQ; b++) begin
                if ($urandom_range(0, rate - 1) == 0) req[b] = ~req[b];
                done[b] = ($urandom_range(0, 2 * rate - 1) == 0);
            end
            modelStep(req, done);
            @(negedge clk);
            check("rand_gnt", int'(gnt), (mCur >= 0) ? (1 << mCur) : 0);
            check("rand_owner", int'(owner), mLast);
            check("rand_busy", int'(busy), (mCur >= 0) ? 1 : 0);
            check("rand_terr", int'(timeout_err), int'(mTerr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_array_arbiter.md
Name: mem_array_arbiter

Overview:
- Round-robin arbiter that shares the single memory array bus among NUM_REQ memory interface masters.
- The array's Addr/DataIn/rdEn/wrEn lines are tristate nets. Only the granted master may enable its drivers.
- The block issues one-hot grants, inserts bus-turnaround idle cycles between owners, and pre-empts any master that holds the bus longer than MAX_HOLD cycles.
- Sits beside the memory array; each memory interface gates its tristate drivers with its gnt bit.

Parameters:
- NUM_REQ, 4, number of memory interface masters (2..8)
- MAX_HOLD, 16, maximum consecutive cycles one master may hold a grant (>=2)
- TURN_CYCLES, 1, idle cycles with no grant between successive owners (1..4)

Ports:
- clk  input  1  system clock, rising edge
- resetH  input  1  asynchronous active-high reset
- req  input  NUM_REQ  per-master bus request, level, held until served
- done  input  NUM_REQ  per-master release pulse; only the bit of the current owner is honoured
- gnt  output  NUM_REQ  one-hot grant, registered; also the tristate output-enable for that master
- owner  output  $clog2(NUM_REQ)  index of current/last owner
- busy  output  1  high while any gnt bit is high
- timeout_err  output  1  one-cycle pulse when the owner is pre-empted by MAX_HOLD

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on resetH.
- Reset values (immediate on resetH, independent of clk): gnt=0, owner=0, busy=0, timeout_err=0, state=IDLE, rr_ptr=0, hold_cnt=0, turn_cnt=0.
- All outputs are registered. gnt is zero or one-hot at all times; the bench checks this with an assertion.
- States: IDLE, GRANT, TURN.
- Arbitration function: search req starting at rr_ptr and wrap modulo NUM_REQ. The first set bit wins.
- IDLE:
  - If any req is set at the clock edge, then on that edge gnt[winner]=1, owner=winner, rr_ptr=(winner+1) mod NUM_REQ, hold_cnt=1, and the state moves to GRANT. Latency from req sampled to gnt high is 1 cycle.
  - If no req is set, the state stays in IDLE.
- GRANT: each edge evaluates the release conditions for the owner o, in priority order:
  - done[o]=1, or req[o]=0: normal release. gnt clears on this edge, the state moves to TURN, turn_cnt=1.
  - hold_cnt==MAX_HOLD with req[o] still 1: pre-emption. gnt clears, timeout_err=1 for exactly one cycle, the state moves to TURN.
  - Otherwise: hold_cnt increments and gnt is unchanged.
- Maximum gnt high time is therefore MAX_HOLD cycles.
- done bits of non-owners are ignored in every state.
- A pre-empted master keeps its req high. It is re-served only when round-robin reaches it again; it gets no priority boost.
- TURN:
  - gnt stays 0. turn_cnt increments each edge.
  - On the edge where turn_cnt==TURN_CYCLES:
    - If any req is set, arbitrate exactly as in IDLE and go directly to GRANT.
    - Otherwise go to IDLE.
  - Result: with requests pending, gnt is low for exactly TURN_CYCLES cycles between owners.
- busy equals the OR of gnt, registered with it; no combinational path.
- owner holds its last value while not in GRANT.
- Simultaneous events:
  - done[o] and hold_cnt==MAX_HOLD on the same edge: treated as a normal release, timeout_err=0.
  - A new req arriving on the same edge that an owner releases is not considered until the TURN arbitration edge.
- Reset mid-grant: gnt drops asynchronously, rr_ptr returns to 0, and any pending requests are re-arbitrated from index 0 after reset deasserts.
- Counter widths: hold_cnt is $clog2(MAX_HOLD+1) bits; turn_cnt is $clog2(TURN_CYCLES+1) bits. Neither counter is permitted to wrap.

Test Plan:
- Reset/idle: assert resetH mid-grant with gnt=4'b0010 -> gnt=0, busy=0 immediately (before next clk edge); owner=0 after release of reset with no req.
- Single request: req=4'b0100 in IDLE -> gnt=4'b0100 one cycle later; done[2] pulse -> gnt=0 next edge; no further grant.
- Round-robin fairness: req=4'b1111 held; each owner pulses done after 3 cycles of grant; TURN_CYCLES=1 -> grant order 0,1,2,3,0; exactly one gnt-low cycle between owners.
- Timeout: req=4'b0001 held, no done, MAX_HOLD=16 -> gnt[0] high 16 cycles, timeout_err one-cycle pulse on the dropping edge, gnt=0 for 1 cycle, then gnt[0] regranted.
- Wrap/priority: rr_ptr=3 after serving master 2, req=4'b1001 -> master 3 granted, then master 0.
- Simultaneous release and timeout: done[1]=1 on the edge where hold_cnt==MAX_HOLD -> gnt drops and timeout_err stays 0. Non-owner done[3] pulse while master 1 is owner -> no effect on gnt.
